// File: rtl/mem_burst_responder.sv
// Multi-cycle data-memory responder: accepts one load/store/block-fill request at a time
// and answers after a fixed latency with a single beat or an aligned BURST_LEN-word burst.
module mem_burst_responder #(
  parameter int unsigned MEM_WORDS = 2048,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_addr,
  output logic        rsp_last
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam int unsigned BW       = $clog2(BURST_LEN);
  localparam logic [15:0] BLK_MASK = ~16'(2 * BURST_LEN - 1);
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

  // state | meaning
  // IDLE  | no request outstanding, ready for a new one
  // WAIT  | request latched, latency counter running
  // RESP  | single read data or write ack on the bus (final beat)
  // BURST | block read beats, one word per cycle
  typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;

  state_t        state;
  logic [3:0]    lat_cnt;
  logic [BW-1:0] beat;
  logic          lat_wr;
  logic          lat_burst;
  logic [15:0]   lat_addr;

  logic [15:0] mem [MEM_WORDS];

  logic        final_beat;
  logic        accept;
  logic        do_launch;
  logic        ln_wr;
  logic        ln_burst;
  logic [15:0] ln_src;
  logic [15:0] ln_addr;
  logic [15:0] nxt_addr;

  function automatic logic [AW-1:0] word_idx(input logic [15:0] a);
    return AW'((32'(a) >> 1) % MEM_WORDS);
  endfunction

  assign final_beat = (state == RESP) || ((state == BURST) && (beat == BW'(BURST_LEN - 1)));
  assign req_ready  = !rst && ((state == IDLE) || final_beat);
  assign accept     = req_valid && req_ready;

  // The first beat is launched either straight from the accept edge (LATENCY==1)
  // or from the latched request when the latency counter expires.
  assign do_launch = (accept && (LATENCY == 1)) || ((state == WAIT) && (lat_cnt == 4'd1));
  assign ln_wr     = (state == WAIT) ? lat_wr : req_wr;
  assign ln_burst  = ((state == WAIT) ? lat_burst : req_burst) && !ln_wr;
  assign ln_src    = (state == WAIT) ? lat_addr : req_addr;
  assign ln_addr   = ln_src & (ln_burst ? BLK_MASK : 16'hFFFE);
  assign nxt_addr  = rsp_addr + 16'd2;

  // Writes commit on the accept edge; accept already excludes reset.
  always_ff @(posedge clk) begin
    if (accept && req_wr) begin
      mem[word_idx(req_addr)] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= 4'd0;
      beat      <= '0;
      lat_wr    <= 1'b0;
      lat_burst <= 1'b0;
      lat_addr  <= 16'h0000;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_addr  <= 16'h0000;
      rsp_last  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      if (accept) begin
        lat_wr    <= req_wr;
        lat_burst <= req_burst;
        lat_addr  <= req_addr;
        lat_cnt   <= LAT_LOAD;
        beat      <= '0;
        state     <= WAIT;
      end else begin
        case (state)
          IDLE: ;
          WAIT: lat_cnt <= lat_cnt - 4'd1;
          RESP: state <= IDLE;
          BURST: begin
            if (final_beat) begin
              state <= IDLE;
            end else begin
              beat      <= beat + 1'b1;
              rsp_valid <= 1'b1;
              rsp_addr  <= nxt_addr;
              rsp_data  <= mem[word_idx(nxt_addr)];
              rsp_last  <= (beat == BW'(BURST_LEN - 2));
            end
          end
        endcase
      end

      if (do_launch) begin
        state     <= ln_burst ? BURST : RESP;
        beat      <= '0;
        rsp_valid <= 1'b1;
        rsp_addr  <= ln_addr;
        rsp_data  <= ln_wr ? 16'h0000 : mem[word_idx(ln_addr)];
        rsp_last  <= !ln_burst || (BURST_LEN == 1);
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Randomized + directed bench for mem_burst_responder against a beat-list reference model.
module tb_mem_burst_responder;

  localparam int LAT = 4;
  localparam int BL  = 8;
  localparam int MW  = 2048;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_wr, req_burst;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_last;
  logic [15:0] rsp_data, rsp_addr;

  logic        c1_rst, c1_valid, c1_wr, c1_burst;
  logic [15:0] c1_addr, c1_wdata;
  logic        c1_ready, c1_rsp_valid, c1_rsp_last;
  logic [15:0] c1_rsp_data, c1_rsp_addr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_until = 0;
  bit acc;
  beat_t q[$];
  logic [15:0] mmem [MW];

  always #5 clk = ~clk;

  mem_burst_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .BURST_LEN(BL)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_last(rsp_last));

  mem_burst_responder #(.MEM_WORDS(MW), .LATENCY(1), .BURST_LEN(BL)) u_lat1 (
    .clk(clk), .rst(c1_rst), .req_valid(c1_valid), .req_ready(c1_ready),
    .req_wr(c1_wr), .req_burst(c1_burst), .req_addr(c1_addr), .req_wdata(c1_wdata),
    .rsp_valid(c1_rsp_valid), .rsp_data(c1_rsp_data), .rsp_addr(c1_rsp_addr),
    .rsp_last(c1_rsp_last));

  function automatic int widx(logic [15:0] a);
    return (int'(a) / 2) % MW;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Expand an accepted request into the list of beats it must produce.
  task automatic model_accept();
    logic [15:0] base;
    int t;
    t = cyc;
    if (req_wr) begin
      mmem[widx(req_addr)] = req_wdata;
      q.push_back('{t + LAT, req_addr & 16'hFFFE, 16'h0000, 1'b1});
      busy_until = t + LAT;
    end else if (!req_burst) begin
      q.push_back('{t + LAT, req_addr & 16'hFFFE, mmem[widx(req_addr)], 1'b1});
      busy_until = t + LAT;
    end else begin
      base = req_addr - (req_addr % 16'(2 * BL));
      for (int k = 0; k < BL; k++)
        q.push_back('{t + LAT + k, base + 16'(2 * k), mmem[widx(base + 16'(2 * k))], k == BL - 1});
      busy_until = t + LAT + BL - 1;
    end
  endtask

  task automatic step();
    bit exp_v;
    #1;
    exp_v = (q.size() > 0) && (q[0].cyc == cyc);
    chk("req_ready", req_ready, !rst && (cyc >= busy_until));
    chk("rsp_valid", rsp_valid, exp_v);
    if (exp_v) begin
      chk("rsp_addr", rsp_addr, q[0].addr);
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_last", rsp_last, q[0].last);
      void'(q.pop_front());
    end
    acc = 1'b0;
    if (rst) begin
      q.delete();
      busy_until = 0;
    end else if (req_valid && cyc >= busy_until) begin
      acc = 1'b1;
      model_accept();
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    req_valid = 1'b1; req_wr = w; req_burst = b; req_addr = a; req_wdata = d;
    for (int i = 0; i < 64; i++) begin
      step();
      if (acc) break;
    end
    chk("accept_timeout", acc, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [15:0] rand_addr();
    return 16'($urandom_range(0, 63) * 2 + $urandom_range(0, 1) + $urandom_range(0, 15) * 4096);
  endfunction

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_burst = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0;
    c1_rst = 1'b1; c1_valid = 1'b0; c1_wr = 1'b0; c1_burst = 1'b0;
    c1_addr = 16'h0; c1_wdata = 16'h0;
    @(posedge clk); cyc++; @(negedge clk);

    // Second reset cycle: outputs cleared, not ready.
    step();
    rst = 1'b0;
    #1;
    chk("reset_rsp_data", rsp_data, 16'h0000);
    chk("reset_rsp_addr", rsp_addr, 16'h0000);
    chk("reset_rsp_last", rsp_last, 1'b0);
    idle(2);

    // Write then back-to-back read of the same word.
    issue(1'b1, 1'b0, 16'h0010, 16'h1234);
    issue(1'b0, 1'b0, 16'h0010, 16'h0000);
    idle(LAT + 1);

    // Preload the working region, then the burst pattern block.
    for (int i = 0; i < 64; i++) issue(1'b1, 1'b0, 16'(2 * i), 16'($urandom));
    for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, 16'(16'h0020 + 2 * i), 16'(16'hA0 + i));
    idle(LAT + 1);

    // Burst from a mid-block address, with a read held and accepted on rsp_last.
    issue(1'b0, 1'b1, 16'h0026, 16'h0000);
    issue(1'b0, 1'b0, 16'h0004, 16'h0000);
    idle(LAT + 2);

    // Address wrap: 0xFFFE and 0x0FFE both map to word 2047.
    issue(1'b1, 1'b0, 16'hFFFE, 16'h5A5A);
    issue(1'b0, 1'b0, 16'h0FFE, 16'h0000);
    issue(1'b0, 1'b1, 16'hFFF2, 16'h0000);
    idle(LAT + BL + 1);

    // Reset during beat 3 of a burst, then re-read the block.
    issue(1'b0, 1'b1, 16'h0020, 16'h0000);
    for (int i = 0; i < 32; i++) begin
      if (q.size() == BL - 3 && q[0].cyc == cyc) break;
      step();
    end
    chk("beat3_reached", q.size(), BL - 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(6);
    issue(1'b0, 1'b1, 16'h002E, 16'h0000);
    idle(LAT + BL + 1);

    // Random traffic over the preloaded region (aliased through the high address bits).
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 149) == 0);
      req_valid = ($urandom_range(0, 9) < 6);
      req_wr    = ($urandom_range(0, 2) == 0);
      req_burst = $urandom_range(0, 1) == 1;
      req_addr  = rand_addr();
      req_wdata = 16'($urandom);
      step();
    end
    rst = 1'b0;
    idle(LAT + BL + 2);
    chk("model_drained", q.size(), 0);

    // LATENCY=1 instance: response in the cycle after acceptance.
    #1;
    chk("lat1_ready_in_reset", c1_ready, 1'b0);
    c1_rst = 1'b0;
    @(negedge clk); #1;
    chk("lat1_ready_idle", c1_ready, 1'b1);
    chk("lat1_rsp_valid_idle", c1_rsp_valid, 1'b0);
    c1_valid = 1'b1; c1_wr = 1'b1; c1_addr = 16'hFFFE; c1_wdata = 16'hBEEF;
    @(negedge clk); #1;
    chk("lat1_wack_valid", c1_rsp_valid, 1'b1);
    chk("lat1_wack_last", c1_rsp_last, 1'b1);
    chk("lat1_wack_data", c1_rsp_data, 16'h0000);
    chk("lat1_wack_addr", c1_rsp_addr, 16'hFFFE);
    chk("lat1_ready_last", c1_ready, 1'b1);
    c1_wr = 1'b0; c1_addr = 16'h0FFE;
    @(negedge clk); #1;
    chk("lat1_rd_valid", c1_rsp_valid, 1'b1);
    chk("lat1_rd_data", c1_rsp_data, 16'hBEEF);
    chk("lat1_rd_addr", c1_rsp_addr, 16'h0FFE);
    c1_valid = 1'b0;
    @(negedge clk); #1;
    chk("lat1_rsp_valid_after", c1_rsp_valid, 1'b0);
    chk("lat1_ready_after", c1_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
